// File: rtl/mixer_ddc_mul_pkg.sv
// Shared widths and pipeline depth for the mixer DDC multiplier scheduler.
package mixer_ddc_mul_pkg;
  localparam int A_W     = 16;
  localparam int B_W     = 8;
  localparam int P_W     = A_W + B_W;
  localparam int MUL_LAT = 2;
endpackage

// File: rtl/mixer_ddc_mul_mulfYi.sv
// Two-stage signed DSP48-style multiplier with clock enable; registers carry no reset.
module mixer_ddc_mul_mulfYi #(
  parameter int A_W = 16,
  parameter int B_W = 8,
  parameter int P_W = 24
) (
  input  logic                  clk,
  input  logic                  ce,
  input  logic signed [A_W-1:0] din0,
  input  logic signed [B_W-1:0] din1,
  output logic signed [P_W-1:0] dout
);
  logic signed [A_W-1:0] a_r;
  logic signed [B_W-1:0] b_r;
  logic signed [P_W-1:0] p_r;

  // Input register stage followed by the product register stage.
  always_ff @(posedge clk) begin
    if (ce) begin
      a_r <= din0;
      b_r <= din1;
      p_r <= a_r * b_r;
    end else begin
      a_r <= a_r;
      b_r <= b_r;
      p_r <= p_r;
    end
  end

  assign dout = p_r;
endmodule

// File: rtl/mixer_ddc_rr_arb.sv
// Round-robin arbiter: first active request at or above ptr, wrapping to 0.
module mixer_ddc_rr_arb #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic          en,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);
  // Priority scan rotated by ptr; the first hit blocks all later candidates.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = 0; k < N; k++) begin
      logic [IW-1:0] jj;
      logic          hit;
      jj        = IW'((int'(ptr) + k) % N);
      hit       = en & ~any & req[jj];
      grant[jj] = grant[jj] | hit;
      idx       = hit ? jj : idx;
      any       = any | hit;
    end
  end
endmodule

// File: rtl/mixer_ddc_mul_sched.sv
// Shares one signed multiplier among NUM_REQ requesters with round-robin grants
// and a tag pipeline that returns each product to its owner.
module mixer_ddc_mul_sched
  import mixer_ddc_mul_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int A_W     = mixer_ddc_mul_pkg::A_W,
  parameter int B_W     = mixer_ddc_mul_pkg::B_W,
  parameter int P_W     = A_W + B_W,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ce,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ*A_W-1:0] req_a,
  input  logic [NUM_REQ*B_W-1:0] req_b,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [NUM_REQ-1:0]     res_valid,
  output logic [IW-1:0]          res_id,
  output logic [P_W-1:0]         res_p
);
  localparam int L = MUL_LAT;

  logic [IW-1:0]      rr_ptr;
  logic [NUM_REQ-1:0] grant;
  logic [IW-1:0]      gnt_idx;
  logic               gnt_any;
  logic signed [A_W-1:0] din0;
  logic signed [B_W-1:0] din1;
  logic signed [P_W-1:0] dout;
  logic [L-1:0]       tag_valid;
  logic [IW-1:0]      tag_id [L];

  mixer_ddc_rr_arb #(.N(NUM_REQ), .IW(IW)) u_arb (
    .req   (req_valid),
    .en    (ce & ~reset),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (gnt_idx),
    .any   (gnt_any)
  );

  assign req_ready = grant;
  assign din0 = req_a[gnt_idx*A_W +: A_W];
  assign din1 = req_b[gnt_idx*B_W +: B_W];

  // Pointer advances past the granted requester only when a transfer happens.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (gnt_any) begin
      rr_ptr <= (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + IW'(1);
    end else begin
      rr_ptr <= rr_ptr;
    end
  end

  // Tag pipeline moves in lockstep with the multiplier registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_valid <= '0;
      for (int i = 0; i < L; i++) tag_id[i] <= '0;
    end else if (ce) begin
      tag_valid <= {tag_valid[L-2:0], gnt_any};
      tag_id[0] <= gnt_idx;
      for (int i = 1; i < L; i++) tag_id[i] <= tag_id[i-1];
    end else begin
      tag_valid <= tag_valid;
      for (int i = 0; i < L; i++) tag_id[i] <= tag_id[i];
    end
  end

  mixer_ddc_mul_mulfYi #(.A_W(A_W), .B_W(B_W), .P_W(P_W)) u_mul (
    .clk  (clk),
    .ce   (ce),
    .din0 (din0),
    .din1 (din1),
    .dout (dout)
  );

  // One-hot owner decode of the final tag stage.
  always_comb begin
    res_valid = '0;
    if (tag_valid[L-1]) begin
      res_valid[tag_id[L-1]] = 1'b1;
    end else begin
      res_valid = '0;
    end
  end

  assign res_id = tag_id[L-1];
  assign res_p  = dout;
endmodule

// File: tb/tb_mixer_ddc_mul_sched.sv
// Randomized bench for mixer_ddc_mul_sched against a queue-based reference model.
module tb_mixer_ddc_mul_sched;
  localparam int N = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ce = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N*16-1:0] req_a = '0;
  logic [N*8-1:0]  req_b = '0;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    res_valid;
  logic [1:0]      res_id;
  logic [23:0]     res_p;

  mixer_ddc_mul_sched #(.NUM_REQ(N)) dut (
    .clk(clk), .reset(reset), .ce(ce),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .res_valid(res_valid), .res_id(res_id), .res_p(res_p)
  );

  always #5 clk = ~clk;

  typedef struct { int due; int id; int prod; } res_t;

  int checks = 0;
  int failures = 0;
  logic pend [N];
  logic signed [15:0] opa [N];
  logic signed [7:0]  opb [N];
  int ptr_m = 0;
  int cnt = 0;
  logic [N-1:0] exp_gnt = '0;
  res_t q[$];

  task automatic check_val(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic load(int k, logic signed [15:0] a, logic signed [7:0] b);
    pend[k] = 1'b1;
    opa[k] = a;
    opb[k] = b;
  endtask

  task automatic load_rand(int k);
    logic signed [15:0] a;
    logic signed [7:0] b;
    a = 16'($urandom);
    b = 8'($urandom);
    if ($urandom_range(0, 7) == 0) a = ($urandom_range(0, 1) == 1) ? 16'sh8000 : 16'sh7FFF;
    if ($urandom_range(0, 7) == 0) b = ($urandom_range(0, 1) == 1) ? 8'sh80 : 8'sh7F;
    load(k, a, b);
  endtask

  // Drive requester state and check the combinational grant against the rule.
  task automatic apply();
    for (int k = 0; k < N; k++) begin
      req_valid[k] = pend[k];
      req_a[k*16 +: 16] = opa[k];
      req_b[k*8 +: 8] = opb[k];
    end
    exp_gnt = '0;
    if (ce && !reset) begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (ptr_m + k) % N;
        if (pend[j] && exp_gnt == '0) exp_gnt[j] = 1'b1;
      end
    end
    #1;
    check_val("req_ready", 32'(req_ready), 32'(exp_gnt));
  endtask

  // Advance the model at the edge, then check outputs on the falling edge.
  task automatic tick();
    logic [23:0] pm;
    @(posedge clk);
    if (ce) cnt++;
    if (reset) begin
      q.delete();
      ptr_m = 0;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (exp_gnt[k]) begin
          res_t r;
          r.due = cnt + 1;
          r.id = k;
          r.prod = int'(opa[k]) * int'(opb[k]);
          q.push_back(r);
          pend[k] = 1'b0;
          ptr_m = (k + 1) % N;
        end
      end
    end
    @(negedge clk);
    while (q.size() > 0 && q[0].due < cnt) q.delete(0);
    if (q.size() > 0 && q[0].due == cnt) begin
      pm = q[0].prod[23:0];
      check_val("res_valid", 32'(res_valid), 32'(1) << q[0].id);
      check_val("res_id", 32'(res_id), 32'(q[0].id));
      check_val("res_p", 32'(res_p), 32'(pm));
    end else begin
      check_val("res_idle", 32'(res_valid), 32'd0);
    end
  endtask

  task automatic run(int cycles, logic [N-1:0] refill, logic ce_v, logic rst_v);
    for (int c = 0; c < cycles; c++) begin
      ce = ce_v;
      reset = rst_v;
      for (int k = 0; k < N; k++) if (refill[k] && !pend[k]) load_rand(k);
      apply();
      tick();
    end
  endtask

  initial begin
    for (int k = 0; k < N; k++) begin
      pend[k] = 1'b0;
      opa[k] = 16'sd0;
      opb[k] = 8'sd0;
    end
    #1;
    ce = 1'b1;
    load(0, 16'sd5, 8'sd1);
    apply();
    check_val("rst_res_valid", 32'(res_valid), 32'd0);
    check_val("rst_res_id", 32'(res_id), 32'd0);
    tick();
    pend[0] = 1'b0;
    run(1, 4'b0000, 1'b1, 1'b1);

    load(0, 16'sd1000, -8'sd3);
    run(4, 4'b0000, 1'b1, 1'b0);

    load(1, -16'sd32768, -8'sd128);
    load(2, 16'sd32767, -8'sd128);
    run(5, 4'b0000, 1'b1, 1'b0);

    run(12, 4'b1111, 1'b1, 1'b0);

    for (int k = 0; k < N; k++) pend[k] = 1'b0;
    load(2, 16'sd7, 8'sd9);
    run(1, 4'b0000, 1'b1, 1'b0);
    run(8, 4'b1001, 1'b1, 1'b0);

    run(2, 4'b1111, 1'b1, 1'b0);
    run(3, 4'b1111, 1'b0, 1'b0);
    run(5, 4'b0000, 1'b1, 1'b0);

    for (int k = 0; k < N; k++) pend[k] = 1'b0;
    run(2, 4'b0110, 1'b1, 1'b0);
    run(1, 4'b0000, 1'b1, 1'b1);
    run(5, 4'b1111, 1'b1, 1'b0);

    for (int c = 0; c < 800; c++) begin
      run(1, 4'($urandom), $urandom_range(0, 9) < 8, $urandom_range(0, 99) == 0);
    end
    run(6, 4'b0000, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
